// File: rtl/snake_pkg.sv
// Shared snake-game definitions used by the food placement logic.
// Holds the default playfield geometry, the placement FSM state type and a
// small helper that folds an out-of-range random index back into the grid.
package snake_pkg;

  localparam int COORD_W = 12;
  localparam int GRID_W  = 40;
  localparam int GRID_H  = 30;
  localparam int CELL    = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW,
    ST_QUERY
  } place_state_t;

  // A raw random value can exceed the grid extent by less than one extent
  // (the raw width is clog2 of the extent), so one subtraction is enough.
  function automatic logic [31:0] foldIndex(input logic [31:0] raw,
                                            input logic [31:0] lim);
    return (raw >= lim) ? (raw - lim) : raw;
  endfunction

endpackage

// File: rtl/food_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the random
// source for food placement. It advances every clock.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset, loads the seed
//   o_state  - current 16-bit LFSR contents
module food_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] o_state
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_state;
  logic        w_feedback;

  assign w_feedback = r_state[15] ^ r_state[13] ^ r_state[12] ^ r_state[10];

  // Shift towards the MSB, inserting the XOR of the tap bits at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
    end else begin
      r_state <= {r_state[14:0], w_feedback};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/food_placer.sv
// Places food items at random free cells of the snake playfield.
// A request picks a random cell, asks the snake-body logic whether that
// cell is occupied, and retries on collision up to MAX_TRIES times.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   i_req, i_req_slot        - place a new item into the given slot
//   o_req_ready              - high while idle (request can be accepted)
//   o_occ_req, o_occ_x/_y    - occupancy query and candidate pixel position
//   i_occ_ack, i_occ_hit     - query answer; hit means the body overlaps
//   o_food_x, o_food_y       - flattened slot positions, slot k at [k*COORD_W +: COORD_W]
//   o_done                   - one-cycle pulse, placement committed
//   o_fail                   - one-cycle pulse, retries exhausted, slot unchanged
module food_placer
  import snake_pkg::*;
#(
  parameter int          COORD_W   = snake_pkg::COORD_W,
  parameter int          GRID_W    = snake_pkg::GRID_W,
  parameter int          GRID_H    = snake_pkg::GRID_H,
  parameter int          CELL      = snake_pkg::CELL,
  parameter int          X_OFF     = 0,
  parameter int          Y_OFF     = 0,
  parameter int          NUM_FOOD  = 2,
  parameter int          MAX_TRIES = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          DEF_COL   = 18,
  parameter int          DEF_ROW   = 18,
  localparam int         SLOT_W    = (NUM_FOOD > 1) ? $clog2(NUM_FOOD) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_req,
  input  logic [SLOT_W-1:0]           i_req_slot,
  output logic                        o_req_ready,
  output logic                        o_occ_req,
  output logic [COORD_W-1:0]          o_occ_x,
  output logic [COORD_W-1:0]          o_occ_y,
  input  logic                        i_occ_ack,
  input  logic                        i_occ_hit,
  output logic [NUM_FOOD*COORD_W-1:0] o_food_x,
  output logic [NUM_FOOD*COORD_W-1:0] o_food_y,
  output logic                        o_done,
  output logic                        o_fail
);

  localparam int CW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int RW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  // Cell index to pixel coordinate, truncated to the coordinate width.
  function automatic logic [COORD_W-1:0] toPixel(input int off,
                                                 input logic [31:0] idx);
    logic [31:0] t;
    t = 32'(off) + idx * 32'(CELL);
    return t[COORD_W-1:0];
  endfunction

  place_state_t r_state, w_next;

  logic [15:0]        w_lfsr;
  logic               w_unused_lfsr;
  logic [31:0]        w_col, w_row;
  logic [COORD_W-1:0] w_candX, w_candY;
  logic               w_collide;
  logic               w_accept, w_commit, w_retry, w_giveUp;

  logic [SLOT_W-1:0]  r_slot;
  logic [TRY_W-1:0]   r_tries;
  logic [COORD_W-1:0] r_occX, r_occY;
  logic [COORD_W-1:0] r_foodX [NUM_FOOD];
  logic [COORD_W-1:0] r_foodY [NUM_FOOD];
  logic               r_done, r_fail;

  food_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .o_state (w_lfsr)
  );

  // Only the low CW+RW bits pick the cell; the rest is deliberately unused.
  assign w_unused_lfsr = ^w_lfsr;

  // Random cell from the LFSR, folded into the grid, then scaled to pixels.
  always_comb begin
    w_col   = foldIndex(32'(w_lfsr[CW-1:0]), 32'(GRID_W));
    w_row   = foldIndex(32'(w_lfsr[CW+RW-1:CW]), 32'(GRID_H));
    w_candX = toPixel(X_OFF, w_col);
    w_candY = toPixel(Y_OFF, w_row);
  end

  // The slot being replaced never collides with its own old position.
  always_comb begin
    w_collide = i_occ_hit;
    for (int k = 0; k < NUM_FOOD; k++) begin
      if ((SLOT_W'(k) != r_slot) && (r_foodX[k] == r_occX) &&
          (r_foodY[k] == r_occY)) begin
        w_collide = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_commit = 1'b0;
    w_retry  = 1'b0;
    w_giveUp = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req && (32'(i_req_slot) < 32'(NUM_FOOD))) begin
          w_accept = 1'b1;
          w_next   = ST_DRAW;
        end
      end
      ST_DRAW: begin
        w_next = ST_QUERY;
      end
      ST_QUERY: begin
        if (i_occ_ack) begin
          if (!w_collide) begin
            w_commit = 1'b1;
            w_next   = ST_IDLE;
          end else if ((32'(r_tries) + 32'd1) >= 32'(MAX_TRIES)) begin
            w_giveUp = 1'b1;
            w_next   = ST_IDLE;
          end else begin
            w_retry = 1'b1;
            w_next  = ST_DRAW;
          end
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Datapath: slot/try bookkeeping, candidate register, slot positions and
  // the registered done/fail pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_tries <= '0;
      r_occX  <= '0;
      r_occY  <= '0;
      r_done  <= 1'b0;
      r_fail  <= 1'b0;
      for (int k = 0; k < NUM_FOOD; k++) begin
        r_foodX[k] <= toPixel(X_OFF, 32'(DEF_COL + 2 * k));
        r_foodY[k] <= toPixel(Y_OFF, 32'(DEF_ROW));
      end
    end else begin
      r_done <= w_commit;
      r_fail <= w_giveUp;
      if (w_accept) begin
        r_slot  <= i_req_slot;
        r_tries <= '0;
      end
      if (r_state == ST_DRAW) begin
        r_occX <= w_candX;
        r_occY <= w_candY;
      end
      if (w_retry || w_giveUp) begin
        r_tries <= r_tries + 1'b1;
      end
      if (w_commit) begin
        for (int k = 0; k < NUM_FOOD; k++) begin
          if (SLOT_W'(k) == r_slot) begin
            r_foodX[k] <= r_occX;
            r_foodY[k] <= r_occY;
          end
        end
      end
    end
  end

  always_comb begin
    o_food_x = '0;
    o_food_y = '0;
    for (int k = 0; k < NUM_FOOD; k++) begin
      o_food_x[k*COORD_W +: COORD_W] = r_foodX[k];
      o_food_y[k*COORD_W +: COORD_W] = r_foodY[k];
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_occ_req   = (r_state == ST_QUERY);
  assign o_occ_x     = r_occX;
  assign o_occ_y     = r_occY;
  assign o_done      = r_done;
  assign o_fail      = r_fail;

endmodule

// File: tb/tb_food_placer.sv
// Directed testbench for food_placer. A default-geometry instance (with
// MAX_TRIES=4) exercises reset, latency, handshake and retry behaviour; a
// tiny-grid instance makes collisions with another slot frequent.
module tb_food_placer;

  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst_n;

  // Main instance signals
  logic          mReq, mReqSlot, mAck, mHit;
  logic          mReady, mOccReq, mDone, mFail;
  logic [CW-1:0] mOccX, mOccY;
  logic [23:0]   mFoodX, mFoodY;

  // Small-grid instance signals
  logic          sReq, sAck, sHit;
  logic [1:0]    sReqSlot;
  logic          sReady, sOccReq, sDone, sFail;
  logic [CW-1:0] sOccX, sOccY;
  logic [35:0]   sFoodX, sFoodY;

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] mx [2];
  logic [CW-1:0] my [2];
  logic [CW-1:0] sx [3];
  logic [CW-1:0] sy [3];

  always #5 clk = ~clk;

  food_placer #(
    .MAX_TRIES (4)
  ) u_main (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (mReq),
    .i_req_slot  (mReqSlot),
    .o_req_ready (mReady),
    .o_occ_req   (mOccReq),
    .o_occ_x     (mOccX),
    .o_occ_y     (mOccY),
    .i_occ_ack   (mAck),
    .i_occ_hit   (mHit),
    .o_food_x    (mFoodX),
    .o_food_y    (mFoodY),
    .o_done      (mDone),
    .o_fail      (mFail)
  );

  food_placer #(
    .GRID_W    (3),
    .GRID_H    (2),
    .NUM_FOOD  (3),
    .MAX_TRIES (16),
    .LFSR_SEED (16'h1234),
    .DEF_COL   (0),
    .DEF_ROW   (0)
  ) u_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (sReq),
    .i_req_slot  (sReqSlot),
    .o_req_ready (sReady),
    .o_occ_req   (sOccReq),
    .o_occ_x     (sOccX),
    .o_occ_y     (sOccY),
    .i_occ_ack   (sAck),
    .i_occ_hit   (sHit),
    .o_food_x    (sFoodX),
    .o_food_y    (sFoodY),
    .o_done      (sDone),
    .o_fail      (sFail)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic slot,
                               input logic ack, input logic hit);
    mReq     = req;
    mReqSlot = slot;
    mAck     = ack;
    mHit     = hit;
  endtask

  function automatic logic [CW-1:0] mFx(input int k);
    return mFoodX[k*CW +: CW];
  endfunction
  function automatic logic [CW-1:0] mFy(input int k);
    return mFoodY[k*CW +: CW];
  endfunction
  function automatic logic [CW-1:0] sFx(input int k);
    return sFoodX[k*CW +: CW];
  endfunction
  function automatic logic [CW-1:0] sFy(input int k);
    return sFoodY[k*CW +: CW];
  endfunction

  task automatic resetTracked();
    mx[0] = 12'd288; my[0] = 12'd288;
    mx[1] = 12'd320; my[1] = 12'd288;
    sx[0] = 12'd0;   sy[0] = 12'd0;
    sx[1] = 12'd32;  sy[1] = 12'd0;
    sx[2] = 12'd64;  sy[2] = 12'd0;
  endtask

  task automatic waitMainQuery(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mOccReq) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("main_query_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitSmallQuery(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sOccReq) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("small_query_timeout", 64'd0, 64'd1);
  endtask

  // Acknowledge the pending main query and check the outcome one cycle later.
  task automatic mainAck(input int slot, input logic hit, output bit committed);
    logic [CW-1:0] cx, cy;
    bit coll;
    cx = mOccX;
    cy = mOccY;
    applyStimulus(1'b0, 1'b0, 1'b1, hit);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    coll = hit;
    for (int k = 0; k < 2; k++) begin
      if (k != slot && cx == mx[k] && cy == my[k]) coll = 1'b1;
    end
    checkOutput("main_done", 64'(mDone), 64'(!coll));
    committed = !coll;
    if (!coll) begin
      mx[slot] = cx;
      my[slot] = cy;
      checkOutput("main_slot_pos", {mFx(slot), mFy(slot)}, {cx, cy});
    end
  endtask

  task automatic mainComplete(input int slot);
    bit ok, c;
    for (int t = 0; t < 20; t++) begin
      waitMainQuery(ok);
      if (!ok) break;
      mainAck(slot, 1'b0, c);
      if (c) break;
    end
  endtask

  initial begin
    bit ok, c, coll, committed;
    logic [CW-1:0] cx, cy;
    int reqs, seen;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    sReq = 1'b0; sReqSlot = 2'd0; sAck = 1'b0; sHit = 1'b0;
    resetTracked();
    repeat (2) @(negedge clk);

    // Reset values while reset is held, then after release
    checkOutput("rst_occ_req", 64'(mOccReq), 64'd0);
    checkOutput("rst_occ_xy", {mOccX, mOccY}, 64'd0);
    checkOutput("rst_done_fail", {mDone, mFail}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_slot0", {mFx(0), mFy(0)}, {12'd288, 12'd288});
    checkOutput("rst_slot1", {mFx(1), mFy(1)}, {12'd320, 12'd288});
    checkOutput("rst_ready", 64'(mReady), 64'd1);
    checkOutput("rst_small_slot2", {sFx(2), sFy(2)}, {12'd64, 12'd0});

    // Minimum latency: accept cycle 0, ack cycle 2, done cycle 3
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lat_c1_occ_req", 64'(mOccReq), 64'd0);
    checkOutput("lat_c1_ready", 64'(mReady), 64'd0);
    @(negedge clk);
    checkOutput("lat_c2_occ_req", 64'(mOccReq), 64'd1);
    cx = mOccX;
    cy = mOccY;
    checkOutput("lat_range", 64'((cx % 16 == 0) && (cx < 640) && (cy % 16 == 0) && (cy < 480)), 64'd1);
    mainAck(0, 1'b0, c);
    checkOutput("lat_c3_ready", 64'(mReady), 64'd1);
    // Request in the done cycle must be accepted
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("done_pulse_width", 64'(mDone), 64'd0);
    checkOutput("samecycle_draw", 64'(mReady), 64'd0);
    @(negedge clk);
    checkOutput("samecycle_query", 64'(mOccReq), 64'd1);
    mainAck(1, 1'b0, c);
    if (!c) mainComplete(1);

    // Ack outside QUERY does nothing
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_ack_done", 64'(mDone), 64'd0);
    checkOutput("idle_ack_slot0", {mFx(0), mFy(0)}, {mx[0], my[0]});

    // Delayed ack: query held stable, extra request ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitMainQuery(ok);
    cx = mOccX;
    cy = mOccY;
    for (int i = 0; i < 5; i++) begin
      checkOutput("wait_stable", {mOccReq, mOccX, mOccY}, {1'b1, cx, cy});
      if (i == 1) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      if (i == 2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    mainAck(0, 1'b0, c);
    if (!c) mainComplete(0);
    @(negedge clk);
    checkOutput("no_queue_c1", 64'(mOccReq), 64'd0);
    @(negedge clk);
    checkOutput("no_queue_c2", 64'(mOccReq), 64'd0);
    checkOutput("no_queue_slot1", {mFx(1), mFy(1)}, {mx[1], my[1]});

    // Reset mid-QUERY aborts and restores defaults
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    waitMainQuery(ok);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_occ", {mOccReq, mOccX, mOccY}, 64'd0);
    checkOutput("midrst_slots", {mFx(0), mFy(0), mFx(1), mFy(1)},
                {12'd288, 12'd288, 12'd320, 12'd288});
    checkOutput("midrst_ready", {mReady, mDone, mFail}, {1'b1, 1'b0, 1'b0});
    resetTracked();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    mainComplete(0);

    // Retry exhaustion with MAX_TRIES=4 and hit always set
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      waitMainQuery(ok);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("exhaust_fail", 64'(mFail), 64'(i == 3));
      checkOutput("exhaust_done", 64'(mDone), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("exhaust_no_query", {mOccReq, mFail}, 64'd0);
    end
    checkOutput("exhaust_slot0", {mFx(0), mFy(0)}, {mx[0], my[0]});

    // Small grid: out-of-range slot request is not accepted
    sReq = 1'b1; sReqSlot = 2'd3;
    @(negedge clk);
    sReq = 1'b0; sReqSlot = 2'd0;
    checkOutput("badslot_ready", 64'(sReady), 64'd1);
    @(negedge clk);
    checkOutput("badslot_no_query", 64'(sOccReq), 64'd0);

    // Small grid: candidate on slot1 must retry, never duplicate slot1
    reqs = 0;
    seen = 0;
    while (reqs < 100 && seen < 2) begin
      sReq = 1'b1; sReqSlot = 2'd0;
      @(negedge clk);
      sReq = 1'b0;
      reqs++;
      committed = 1'b0;
      for (int t = 0; t < 16 && !committed; t++) begin
        waitSmallQuery(ok);
        if (!ok) break;
        cx = sOccX;
        cy = sOccY;
        coll = (cx == sx[1] && cy == sy[1]) || (cx == sx[2] && cy == sy[2]);
        sAck = 1'b1;
        @(negedge clk);
        sAck = 1'b0;
        checkOutput("small_done", 64'(sDone), 64'(!coll));
        if (coll) begin
          seen++;
        end else begin
          committed = 1'b1;
          sx[0] = cx;
          sy[0] = cy;
          checkOutput("small_slot0", {sFx(0), sFy(0)}, {cx, cy});
        end
      end
      checkOutput("small_slot1_intact", {sFx(1), sFy(1)}, {12'd32, 12'd0});
    end
    checkOutput("small_collision_seen", 64'(seen >= 1), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 SHALL have parameter COORD_W, default 12, pixel coordinate width.
REQ-002 SHALL have parameter GRID_W, default 40, playfield columns (cells).
REQ-003 SHALL have parameter GRID_H, default 30, playfield rows (cells).
REQ-004 SHALL have parameter CELL, default 16, pixels per cell.
REQ-005 SHALL have parameters X_OFF and Y_OFF, default 0, pixel origin of cell (0,0).
REQ-006 SHALL have parameter NUM_FOOD, default 2, number of independent food slots.
REQ-007 SHALL have parameter MAX_TRIES, default 16, collision retries before giving up.
REQ-008 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR seed (0 replaced by 1).
REQ-009 SHALL have parameters DEF_COL (default 18) and DEF_ROW (default 18), reset cell of slot 0.
REQ-010 clk  in  1  clock; reset rst_n, asynchronous, active-low.
REQ-011 rst_n  in  1  asynchronous active-low reset.
REQ-012 req  in  1  place a new food item into slot req_slot.
REQ-013 req_slot  in  clog2(NUM_FOOD)  target slot index.
REQ-014 req_ready  out  1  high only in IDLE.
REQ-015 occ_req  out  1  occupancy query valid to snake-body logic.
REQ-016 occ_x, occ_y  out  COORD_W each  candidate pixel coordinate.
REQ-017 occ_ack  in  1  query answered this cycle.
REQ-018 occ_hit  in  1  candidate overlaps snake body, valid with occ_ack.
REQ-019 food_x, food_y  out  NUM_FOOD*COORD_W each  flattened slot positions, slot k at bits [k*COORD_W +: COORD_W].
REQ-020 done  out  1  one-cycle pulse, placement committed.
REQ-021 fail  out  1  one-cycle pulse, MAX_TRIES exhausted, slot unchanged.

Function
REQ-022 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clock regardless of state.
REQ-023 FSM states SHALL be IDLE, DRAW, QUERY; accept = req && req_ready, latches req_slot, clears try counter, IDLE->DRAW.
REQ-024 DRAW: raw col = LFSR[CW-1:0], CW=clog2(GRID_W); col = raw>=GRID_W ? raw-GRID_W : raw; row same from LFSR[CW+RW-1:CW], RW=clog2(GRID_H); DRAW->QUERY.
REQ-025 Candidate pixel SHALL be X_OFF+col*CELL, Y_OFF+row*CELL, truncated to COORD_W, registered into occ_x/occ_y.
REQ-026 QUERY: occ_req SHALL be high, occ_x/occ_y stable, until the cycle occ_ack is sampled high.
REQ-027 Collision = occ_hit || candidate equals position of any other slot; own slot's old position is not a collision.
REQ-028 On ack without collision: food[slot] <= candidate, done pulsed next cycle, QUERY->IDLE.
REQ-029 On ack with collision: try counter increments; if it reaches MAX_TRIES, fail pulsed, slot unchanged, ->IDLE; else ->DRAW.
REQ-030 Minimum latency: req accepted in cycle 0, occ_ack in cycle 2, done high in cycle 3.
REQ-031 req while req_ready low SHALL be ignored, not queued; req in the same cycle done is high SHALL be accepted.
REQ-032 req_slot >= NUM_FOOD SHALL be ignored (no accept).
REQ-033 occ_ack outside QUERY SHALL be ignored.

Reset
REQ-034 On rst_n low: state IDLE, occ_req 0, occ_x/occ_y 0, done 0, fail 0, try counter 0, LFSR = seed.
REQ-035 On reset, slot k SHALL be at pixel (X_OFF+(DEF_COL+2k)*CELL, Y_OFF+DEF_ROW*CELL).
REQ-036 Reset mid-operation SHALL abort immediately; no partial slot update.

Structure
REQ-037 COORD_W, GRID_W, GRID_H, CELL and the FSM state enum SHALL live in shared package snake_pkg.
REQ-038 LFSR SHALL be a sub-module food_lfsr (parameter SEED, output 16-bit state).

Verification
REQ-039 Reset, defaults -> food slot0 (288,288), slot1 (320,288), req_ready 1, occ_req 0.
REQ-040 req slot0 cycle 0, occ_ack=1 hit=0 in cycle 2 -> done cycle 3; x%16==0, x<640; y%16==0, y<480.
REQ-041 MAX_TRIES=4, occ_hit held 1 -> exactly 4 acks, fail pulse once, slot0 stays (288,288), done never.
REQ-042 occ_ack delayed 5 cycles -> occ_req and occ_x/occ_y constant all 5 cycles; extra req during wait ignored.
REQ-043 Force candidate equal to slot1 position for slot0 request -> retry counted, slot1 never duplicated.
REQ-044 rst_n low during QUERY -> outputs at REQ-034/035 values, next req completes normally.
